// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory port between an I-cache and a
// D-cache. Block fills issue WORDS_PER_BLOCK consecutive reads and forward
// each returned word to the owning cache. D-cache single-word writes take
// one write cycle. When both caches request together, the one not served
// last wins.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_req/i_addr        I-cache fill request and miss address
//   d_req/d_we/d_addr   D-cache request (d_we=1 single-word write, 0 fill)
//   d_wdata             D-cache write-through data
//   *_grant             one-cycle pulse on acceptance (the cycle leaving IDLE)
//   *_data/_data_valid  forwarded fill word and its strobe
//   *_word              index of the forwarded word within the block
//   *_done              one-cycle pulse when the transaction completes
//   mem_*               main-memory request/response port
//   busy                high whenever a transaction is in progress
module cache_mem_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic [15:0] i_data,
  output logic [15:0] d_data,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [2:0]  i_word,
  output logic [2:0]  d_word,
  output logic        i_done,
  output logic        d_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        busy
);

  localparam logic [3:0] NWORDS = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LAST   = 4'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  ret_cnt_q, ret_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        last_d_q, last_d_d;
  logic        mask_i_q, mask_i_d;
  logic        mask_d_q, mask_d_d;
  // Cleared asynchronously by reset so no grant can be issued while rst is
  // low; arbitration resumes from the first edge after reset release.
  logic        arb_en_q;

  logic i_req_eff, d_req_eff;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[3:0], d_addr[0]};

  assign i_req_eff = i_req & ~mask_i_q;
  assign d_req_eff = d_req & ~mask_d_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_d_d     = last_d_q;
    mask_i_d     = 1'b0;
    mask_d_d     = 1'b0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data       = '0;
    d_data       = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    i_word       = '0;
    d_word       = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_en_q) begin
          if (i_req_eff && (!d_req_eff || last_d_q)) begin
            i_grant     = 1'b1;
            last_d_d    = 1'b0;
            state_d     = IFILL;
            addr_d      = {i_addr[15:4], 4'b0000};
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
          end else if (d_req_eff) begin
            d_grant     = 1'b1;
            last_d_d    = 1'b1;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            if (d_we) begin
              state_d = DWRITE;
              addr_d  = {d_addr[15:1], 1'b0};
              wdata_d = d_wdata;
            end else begin
              state_d = DFILL;
              addr_d  = {d_addr[15:4], 4'b0000};
            end
          end
        end
      end

      IFILL, DFILL: begin
        if (issue_cnt_q < NWORDS) begin
          mem_enable  = 1'b1;
          mem_addr    = addr_q + {11'b0, issue_cnt_q, 1'b0};
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (mem_data_valid) begin
          ret_cnt_d = ret_cnt_q + 4'd1;
          if (state_q == IFILL) begin
            i_data_valid = 1'b1;
            i_data       = mem_data_out;
            i_word       = ret_cnt_q[2:0];
          end else begin
            d_data_valid = 1'b1;
            d_data       = mem_data_out;
            d_word       = ret_cnt_q[2:0];
          end
          if (ret_cnt_q == LAST) begin
            state_d = IDLE;
            if (state_q == IFILL) begin
              i_done   = 1'b1;
              mask_i_d = 1'b1;
            end else begin
              d_done   = 1'b1;
              mask_d_d = 1'b1;
            end
          end
        end
      end

      DWRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = addr_q;
        mem_data_in = wdata_q;
        d_done      = 1'b1;
        mask_d_d    = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_d_q    <= 1'b1;
      mask_i_q    <= 1'b0;
      mask_d_q    <= 1'b0;
      arb_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_d_q    <= last_d_d;
      mask_i_q    <= mask_i_d;
      mask_d_q    <= mask_d_d;
      arb_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle main-memory model
// whose read data equals the read address.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant;
  logic [15:0] i_data, d_data;
  logic        i_data_valid, d_data_valid;
  logic [2:0]  i_word, d_word;
  logic        i_done, d_done;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        busy;
  logic        spur;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data(i_data), .d_data(d_data),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_word(i_word), .d_word(d_word),
    .i_done(i_done), .d_done(d_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .busy(busy)
  );

  // Memory model: read issued in cycle N returns in cycle N+4; shares rst.
  logic [16:0] p0, p1, p2, p3;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0 <= '0; p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      p0 <= {mem_enable & ~mem_wr, mem_addr};
      p1 <= p0;
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign mem_data_valid = p3[16] | spur;
  assign mem_data_out   = p3[16] ? p3[15:0] : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Caller has driven the request in an IDLE cycle; checks the grant, then
  // the 12 cycles of the fill. The request is dropped after cycle drop_k.
  task automatic run_fill(input bit is_d, input logic [15:0] addr, input int drop_k);
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    #1;
    check_eq(is_d ? "d_grant" : "i_grant", 32'(is_d ? d_grant : i_grant), 32'd1);
    check_eq("other_grant", 32'(is_d ? i_grant : d_grant), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("fill_busy", 32'(busy), 32'd1);
      check_eq("fill_mem_en", 32'(mem_enable), 32'(k <= 8));
      check_eq("fill_mem_wr", 32'(mem_wr), 32'd0);
      if (k <= 8)
        check_eq("fill_mem_addr", 32'(mem_addr), 32'(base) + 32'(2 * (k - 1)));
      check_eq("fill_dvalid", 32'(is_d ? d_data_valid : i_data_valid), 32'(k >= 5));
      check_eq("fill_other_dvalid", 32'(is_d ? i_data_valid : d_data_valid), 32'd0);
      if (k >= 5) begin
        check_eq("fill_data", 32'(is_d ? d_data : i_data), 32'(base) + 32'(2 * (k - 5)));
        check_eq("fill_word", 32'(is_d ? d_word : i_word), 32'(k - 5));
      end
      check_eq("fill_done", 32'(is_d ? d_done : i_done), 32'(k == 12));
      if (k == drop_k) begin
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; spur = 1'b0;
    i_req = 1'b1; i_addr = 16'h1111;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_i_grant", 32'(i_grant), 32'd0);
    check_eq("rst_mem_en", 32'(mem_enable), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_din", 32'(mem_data_in), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_i_done", 32'(i_done), 32'd0);
    i_req = 1'b0;
    rst = 1'b1;
    step();
    step();

    // I fill from 0x1236; request held through done and the masked cycle.
    i_req = 1'b1; i_addr = 16'h1236;
    run_fill(1'b0, 16'h1236, 99);
    step();
    check_eq("mask_i_grant", 32'(i_grant), 32'd0);
    check_eq("mask_busy", 32'(busy), 32'd0);
    check_eq("mask_mem_en", 32'(mem_enable), 32'd0);
    i_req = 1'b0;
    step();
    check_eq("post_mask_busy", 32'(busy), 32'd0);

    // D write-through.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h4003; d_wdata = 16'hBEEF;
    #1;
    check_eq("dw_grant", 32'(d_grant), 32'd1);
    check_eq("dw_grant_mem_en", 32'(mem_enable), 32'd0);
    step();
    check_eq("dw_mem_en", 32'(mem_enable), 32'd1);
    check_eq("dw_mem_wr", 32'(mem_wr), 32'd1);
    check_eq("dw_mem_addr", 32'(mem_addr), 32'h4002);
    check_eq("dw_mem_din", 32'(mem_data_in), 32'hBEEF);
    check_eq("dw_done", 32'(d_done), 32'd1);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check_eq("dw_after_busy", 32'(busy), 32'd0);
    check_eq("dw_after_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("dw_after_done", 32'(d_done), 32'd0);

    // Tie with D served last: I first, D in the idle cycle after i_done.
    // D drops its request early and must still complete.
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h2004; d_addr = 16'h300A;
    run_fill(1'b0, 16'h2004, 12);
    step();
    run_fill(1'b1, 16'h300A, 2);
    step();
    check_eq("tie1_idle_busy", 32'(busy), 32'd0);

    // Second tie, D again served last: I wins again.
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h8000; d_addr = 16'h9000;
    run_fill(1'b0, 16'h8000, 12);
    step();
    run_fill(1'b1, 16'h9000, 12);
    step();

    // I served last, then a tie: D wins.
    i_req = 1'b1; i_addr = 16'h7000;
    run_fill(1'b0, 16'h7000, 12);
    step();
    step();
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'hA010; d_addr = 16'hB020;
    run_fill(1'b1, 16'hB020, 12);
    step();
    run_fill(1'b0, 16'hA010, 12);
    step();

    // Spurious memory valid while idle.
    spur = 1'b1;
    #1;
    check_eq("spur_i_dvalid", 32'(i_data_valid), 32'd0);
    check_eq("spur_d_dvalid", 32'(d_data_valid), 32'd0);
    check_eq("spur_busy", 32'(busy), 32'd0);
    step();
    spur = 1'b0;

    // Reset at fill word 3, then a fresh fill.
    i_req = 1'b1; i_addr = 16'h5000;
    #1;
    check_eq("rr_grant", 32'(i_grant), 32'd1);
    for (int k = 1; k <= 8; k++) step();
    check_eq("rr_word3", 32'(i_word), 32'd3);
    check_eq("rr_word3_valid", 32'(i_data_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rr_dvalid", 32'(i_data_valid), 32'd0);
    check_eq("rr_data", 32'(i_data), 32'd0);
    check_eq("rr_busy", 32'(busy), 32'd0);
    check_eq("rr_mem_en", 32'(mem_enable), 32'd0);
    check_eq("rr_grant_in_rst", 32'(i_grant), 32'd0);
    i_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("rr_no_done", 32'(i_done), 32'd0);
      check_eq("rr_no_dvalid", 32'(i_data_valid), 32'd0);
    end
    i_req = 1'b1; i_addr = 16'h6010;
    run_fill(1'b0, 16'h6010, 12);
    step();
    check_eq("rr_end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
